fc_tiled_engine: RTL and testbench

- Parametrised fully-connected layer engine for the EPU.
- Computes out[o] = requant(sum_i in[i]*W[o][i] + (bias[o] << BIAS_SHIFT)) for o < out_ch and i < in_ch.
- Processes NUM_PE output channels per tile, one input element per cycle, with one wide weight word per cycle.
- Reads configuration, bias and input words, and writes output, through sp_ram_intf.compute ports; weights come from a dedicated wide SRAM port.

---
 rtl/fc_pkg.sv | 25 ++
 rtl/sp_ram_intf.sv | 12 +
 rtl/fc_requant.sv | 41 ++++
 rtl/fc_tiled_engine.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_fc_tiled_engine.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types and constants for the tiled fully-connected engine.
// Config word layout: word0 {relu_en[31], shift[4:0]}, word1 in_ch, word2 out_ch.
package fc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_BIAS,
        ST_MAC,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } fc_state_t;

    localparam logic [31:0] CFG_WORD_MODE   = 32'd0;
    localparam logic [31:0] CFG_WORD_IN_CH  = 32'd1;
    localparam logic [31:0] CFG_WORD_OUT_CH = 32'd2;

    localparam int RELU_BIT  = 31;
    localparam int SHIFT_MSB = 4;

    localparam logic WRITE_ENB = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

endpackage

// File: rtl/sp_ram_intf.sv
// Single-port SRAM interface: 1-cycle read latency, rdata valid the cycle after cs.
interface sp_ram_intf;
    logic        cs;
    logic        W_req;
    logic        oe;
    logic [31:0] addr;
    logic [31:0] W_data;
    logic [31:0] rdata;

    modport compute (output cs, W_req, oe, addr, W_data, input rdata);
    modport memory  (input cs, W_req, oe, addr, W_data, output rdata);
endinterface

// File: rtl/fc_requant.sv
// Per-lane requantisation: round-half-up arithmetic shift, saturate to OUT_W, optional relu.
module fc_requant #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [4:0]       shift_i,
    input  logic             relu_en_i,
    output logic [OUT_W-1:0] res_o
);
    localparam int EXT_W = ACC_W + 1;
    localparam logic signed [EXT_W-1:0] MAX_V = EXT_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [EXT_W-1:0] MIN_V = ~MAX_V;

    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] sum;
    logic signed [EXT_W-1:0] shr;
    logic        [OUT_W-1:0] sat;

    // One extra bit so the rounding add cannot wrap near the accumulator limits.
    always_comb begin
        rnd = '0;
        if (shift_i != 5'd0) begin
            rnd = EXT_W'(1) << (shift_i - 5'd1);
        end
        sum = $signed({acc_i[ACC_W-1], acc_i}) + rnd;
        shr = sum >>> shift_i;
        if (shr > MAX_V) begin
            sat = MAX_V[OUT_W-1:0];
        end else if (shr < MIN_V) begin
            sat = MIN_V[OUT_W-1:0];
        end else begin
            sat = shr[OUT_W-1:0];
        end
        if (relu_en_i && sat[OUT_W-1]) begin
            sat = '0;
        end
        res_o = sat;
    end

endmodule

// File: rtl/fc_tiled_engine.sv
// Tiled fully-connected layer engine: NUM_PE output channels per tile, one input
// element and one wide weight word per cycle, requantised results written per lane.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_CFG   | read relu/shift, in_ch, out_ch (4 cycles), check legality
// ST_BIAS  | load NUM_PE biases into the accumulators (NUM_PE+1 cycles)
// ST_MAC   | stream in_ch inputs and weight words
// ST_DRAIN | let the last two pipeline stages land in the accumulators
// ST_WRITE | requantise and write one valid lane per cycle
// ST_DONE  | one-cycle finish pulse
module fc_tiled_engine
    import fc_pkg::*;
#(
    parameter int NUM_PE     = 16,
    parameter int IN_W       = 8,
    parameter int WGT_W      = 8,
    parameter int BIAS_W     = 16,
    parameter int BIAS_SHIFT = 5,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 8,
    parameter int MAX_IN     = 1024,
    parameter int MAX_OUT    = 256
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    output logic                    busy,
    output logic                    finish,
    output logic                    cfg_err,
    sp_ram_intf.compute             param_intf,
    sp_ram_intf.compute             bias_intf,
    sp_ram_intf.compute             input_intf,
    sp_ram_intf.compute             output_intf,
    output logic                    wgt_cs,
    output logic [31:0]             wgt_addr,
    input  logic [NUM_PE*WGT_W-1:0] wgt_rdata
);
    localparam int CNT_W  = $clog2(MAX_IN + NUM_PE + 2);
    localparam int IN_CW  = $clog2(MAX_IN + 1);
    localparam int OUT_CW = $clog2(MAX_OUT + 1);
    localparam int TILE_W = $clog2(MAX_OUT + 1);
    localparam int PROD_W = IN_W + WGT_W;

    fc_state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [IN_CW-1:0]  in_ch_q, in_ch_d;
    logic [OUT_CW-1:0] out_ch_q, out_ch_d;
    logic [4:0]        shift_q, shift_d;
    logic              relu_q, relu_d;
    logic              in_bad_q, in_bad_d;
    logic              cfg_err_q, cfg_err_d;
    logic              rd_vld_q, rd_vld_d;
    logic              mac_vld_q, mac_vld_d;
    logic [IN_W-1:0]   in_q, in_d;
    logic [NUM_PE*WGT_W-1:0] wgt_q, wgt_d;
    logic signed [ACC_W-1:0] acc_q [NUM_PE];
    logic signed [ACC_W-1:0] acc_d [NUM_PE];

    logic signed [PROD_W-1:0] prod [NUM_PE];
    logic [31:0]       base_ch;
    logic [31:0]       chan;
    logic [BIAS_W-1:0] bias_raw;
    logic [ACC_W-1:0]  bias_init;
    logic [ACC_W-1:0]  sel_acc;
    logic [OUT_W-1:0]  q_res;
    logic              unused_rdata;

    assign unused_rdata = ^{param_intf.rdata, bias_intf.rdata, input_intf.rdata, output_intf.rdata};

    assign base_ch   = 32'(tile_q) * 32'(NUM_PE);
    assign chan      = base_ch + 32'(cnt_q);
    assign bias_raw  = bias_intf.rdata[BIAS_W-1:0];
    assign bias_init = {{(ACC_W - BIAS_W){bias_raw[BIAS_W-1]}}, bias_raw} << BIAS_SHIFT;

    assign busy    = (state_q != ST_IDLE);
    assign finish  = (state_q == ST_DONE);
    assign cfg_err = cfg_err_q;

    always_comb begin
        for (int p = 0; p < NUM_PE; p++) begin
            prod[p] = $signed(in_q) * $signed(wgt_q[p*WGT_W +: WGT_W]);
        end
    end

    always_comb begin
        sel_acc = '0;
        for (int p = 0; p < NUM_PE; p++) begin
            if (cnt_q == CNT_W'(p)) begin
                sel_acc = acc_q[p];
            end
        end
    end

    fc_requant #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W)
    ) u_requant (
        .acc_i     (sel_acc),
        .shift_i   (shift_q),
        .relu_en_i (relu_q),
        .res_o     (q_res)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tile_d    = tile_q;
        in_ch_d   = in_ch_q;
        out_ch_d  = out_ch_q;
        shift_d   = shift_q;
        relu_d    = relu_q;
        in_bad_d  = in_bad_q;
        cfg_err_d = cfg_err_q;
        rd_vld_d  = 1'b0;
        mac_vld_d = rd_vld_q;
        in_d      = input_intf.rdata[IN_W-1:0];
        wgt_d     = wgt_rdata;
        acc_d     = acc_q;

        param_intf.cs      = 1'b0;
        param_intf.W_req   = WRITE_DIS;
        param_intf.oe      = 1'b1;
        param_intf.addr    = '0;
        param_intf.W_data  = '0;
        bias_intf.cs       = 1'b0;
        bias_intf.W_req    = WRITE_DIS;
        bias_intf.oe       = 1'b1;
        bias_intf.addr     = '0;
        bias_intf.W_data   = '0;
        input_intf.cs      = 1'b0;
        input_intf.W_req   = WRITE_DIS;
        input_intf.oe      = 1'b1;
        input_intf.addr    = '0;
        input_intf.W_data  = '0;
        output_intf.cs     = 1'b0;
        output_intf.W_req  = WRITE_DIS;
        output_intf.oe     = 1'b1;
        output_intf.addr   = '0;
        output_intf.W_data = '0;
        wgt_cs             = 1'b0;
        wgt_addr           = '0;

        // Product registered one cycle earlier lands in every lane.
        if (mac_vld_q) begin
            for (int p = 0; p < NUM_PE; p++) begin
                acc_d[p] = acc_q[p] + {{(ACC_W - PROD_W){prod[p][PROD_W-1]}}, prod[p]};
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_CFG;
                    cnt_d     = '0;
                    tile_d    = '0;
                    cfg_err_d = 1'b0;
                end
            end
            ST_CFG: begin
                cnt_d = cnt_q + CNT_W'(1);
                unique case (cnt_q[1:0])
                    2'd0: begin
                        param_intf.cs   = 1'b1;
                        param_intf.addr = CFG_WORD_MODE;
                    end
                    2'd1: begin
                        param_intf.cs   = 1'b1;
                        param_intf.addr = CFG_WORD_IN_CH;
                        relu_d  = param_intf.rdata[RELU_BIT];
                        shift_d = param_intf.rdata[SHIFT_MSB:0];
                    end
                    2'd2: begin
                        param_intf.cs   = 1'b1;
                        param_intf.addr = CFG_WORD_OUT_CH;
                        in_ch_d  = param_intf.rdata[IN_CW-1:0];
                        in_bad_d = (param_intf.rdata == 32'd0) || (param_intf.rdata > 32'(MAX_IN));
                    end
                    default: begin
                        out_ch_d = param_intf.rdata[OUT_CW-1:0];
                        cnt_d    = '0;
                        if (in_bad_q || (param_intf.rdata == 32'd0) ||
                            (param_intf.rdata > 32'(MAX_OUT))) begin
                            cfg_err_d = 1'b1;
                            state_d   = ST_DONE;
                        end else begin
                            state_d = ST_BIAS;
                        end
                    end
                endcase
            end
            ST_BIAS: begin
                if ((cnt_q < CNT_W'(NUM_PE)) && (chan < 32'(out_ch_q))) begin
                    bias_intf.cs   = 1'b1;
                    bias_intf.addr = chan;
                end
                // Bias read issued last cycle belongs to lane cnt_q-1.
                for (int p = 0; p < NUM_PE; p++) begin
                    if (cnt_q == CNT_W'(p + 1)) begin
                        acc_d[p] = ((chan - 32'd1) < 32'(out_ch_q)) ? bias_init : '0;
                    end
                end
                if (cnt_q == CNT_W'(NUM_PE)) begin
                    state_d = ST_MAC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_MAC: begin
                input_intf.cs   = 1'b1;
                input_intf.addr = 32'(cnt_q);
                wgt_cs          = 1'b1;
                wgt_addr        = 32'(tile_q) * 32'(in_ch_q) + 32'(cnt_q);
                rd_vld_d        = 1'b1;
                if (cnt_q + CNT_W'(1) == CNT_W'(in_ch_q)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_WRITE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                output_intf.cs     = 1'b1;
                output_intf.W_req  = WRITE_ENB;
                output_intf.addr   = chan;
                output_intf.W_data = {{(32 - OUT_W){q_res[OUT_W-1]}}, q_res};
                if ((chan + 32'd1 == 32'(out_ch_q)) || (cnt_q == CNT_W'(NUM_PE - 1))) begin
                    cnt_d = '0;
                    if (base_ch + 32'(NUM_PE) >= 32'(out_ch_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BIAS;
                        tile_d  = tile_q + TILE_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tile_q    <= '0;
            in_ch_q   <= '0;
            out_ch_q  <= '0;
            shift_q   <= '0;
            relu_q    <= 1'b0;
            in_bad_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            mac_vld_q <= 1'b0;
            in_q      <= '0;
            wgt_q     <= '0;
            acc_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tile_q    <= tile_d;
            in_ch_q   <= in_ch_d;
            out_ch_q  <= out_ch_d;
            shift_q   <= shift_d;
            relu_q    <= relu_d;
            in_bad_q  <= in_bad_d;
            cfg_err_q <= cfg_err_d;
            rd_vld_q  <= rd_vld_d;
            mac_vld_q <= mac_vld_d;
            in_q      <= in_d;
            wgt_q     <= wgt_d;
            acc_q     <= acc_d;
        end
    end

endmodule

// File: tb/tb_fc_tiled_engine.sv
// Directed bench for fc_tiled_engine with behavioural SRAM models and hand-computed results.
module tb_fc_tiled_engine;
    import fc_pkg::*;

    localparam int NUM_PE = 16;
    localparam int WGT_W  = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic busy, finish, cfg_err;
    logic wgt_cs;
    logic [31:0] wgt_addr;
    logic [NUM_PE*WGT_W-1:0] wgt_rdata = '0;

    sp_ram_intf param_if ();
    sp_ram_intf bias_if ();
    sp_ram_intf input_if ();
    sp_ram_intf output_if ();

    fc_tiled_engine #(.NUM_PE(NUM_PE)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .busy        (busy),
        .finish      (finish),
        .cfg_err     (cfg_err),
        .param_intf  (param_if),
        .bias_intf   (bias_if),
        .input_intf  (input_if),
        .output_intf (output_if),
        .wgt_cs      (wgt_cs),
        .wgt_addr    (wgt_addr),
        .wgt_rdata   (wgt_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0]       param_mem [4];
    logic [31:0]       bias_mem  [64];
    logic [31:0]       in_mem    [64];
    logic [31:0]       out_mem   [64];
    logic signed [7:0] wmem      [64][64];
    int cur_in = 1;
    int wr_cnt = 0;
    int bad_wr = 0;
    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [NUM_PE*WGT_W-1:0] wgt_word(input logic [31:0] a);
        logic [NUM_PE*WGT_W-1:0] w;
        int t, i, o;
        w = '0;
        if (cur_in > 0) begin
            t = int'(a) / cur_in;
            i = int'(a) % cur_in;
            for (int p = 0; p < NUM_PE; p++) begin
                o = t * NUM_PE + p;
                if (o < 64 && i < 64) w[p*WGT_W +: WGT_W] = wmem[o][i];
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (param_if.cs) param_if.rdata <= param_mem[param_if.addr[1:0]];
        if (bias_if.cs)  bias_if.rdata  <= bias_mem[bias_if.addr[5:0]];
        if (input_if.cs) input_if.rdata <= in_mem[input_if.addr[5:0]];
        if (wgt_cs)      wgt_rdata      <= wgt_word(wgt_addr);
        if (output_if.cs && output_if.W_req == WRITE_ENB) begin
            wr_cnt++;
            if (output_if.addr < 32'd64) out_mem[output_if.addr[5:0]] <= output_if.W_data;
            else bad_wr++;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 64; a++) begin
            bias_mem[a] = '0;
            in_mem[a]   = '0;
            out_mem[a]  = 32'hDEAD_BEEF;
            for (int b = 0; b < 64; b++) wmem[a][b] = '0;
        end
        wr_cnt = 0;
        bad_wr = 0;
    endtask

    task automatic set_cfg(input int in_ch, input int out_ch, input int shift, input int relu);
        param_mem[0] = (relu != 0 ? 32'h8000_0000 : 32'h0) | (32'(shift) & 32'h1F);
        param_mem[1] = 32'(in_ch);
        param_mem[2] = 32'(out_ch);
        param_mem[3] = '0;
        cur_in = in_ch;
    endtask

    // Launch, count busy cycles to finish, poke start mid-run and on the finish cycle.
    task automatic run(input string tag, input int exp_cycles, output logic err_at_fin);
        int cycles;
        logic got_fin;
        cycles = 0;
        got_fin = 1'b0;
        err_at_fin = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            if (busy) cycles++;
            if (finish) begin
                got_fin = 1'b1;
                err_at_fin = cfg_err;
                break;
            end
            start = (cycles == 10);
            @(negedge clk);
        end
        check_val({tag, "_finish_seen"}, 32'(got_fin), 32'd1);
        check_val({tag, "_cycles"}, 32'(cycles), 32'(exp_cycles));
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val({tag, "_finish_len"}, 32'(finish), 32'd0);
        check_val({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    logic e;

    initial begin
        clear_mem();
        set_cfg(1, 1, 0, 0);
        repeat (3) @(negedge clk);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_finish", 32'(finish), 32'd0);
        check_val("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_val("rst_cs", 32'({param_if.cs, bias_if.cs, input_if.cs, output_if.cs, wgt_cs}), 32'd0);
        check_val("rst_wreq", 32'(output_if.W_req), 32'(WRITE_DIS));
        check_val("rst_addr", output_if.addr | wgt_addr | param_if.addr, 32'd0);
        rstn = 1'b1;

        // basic dot product, two channels
        clear_mem();
        set_cfg(4, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in_mem[i] = 32'(i + 1);
            wmem[0][i] = 8'sd1;
            wmem[1][i] = -8'sd1;
        end
        run("t1", 30, e);
        check_val("t1_err", 32'(e), 32'd0);
        check_val("t1_out0", out_mem[0], 32'd10);
        check_val("t1_out1", out_mem[1], 32'hFFFF_FFF6);
        check_val("t1_wr_cnt", 32'(wr_cnt), 32'd2);
        check_val("t1_no_out2", out_mem[2], 32'hDEAD_BEEF);

        // relu
        wr_cnt = 0;
        set_cfg(4, 2, 0, 1);
        run("t2", 30, e);
        check_val("t2_out0", out_mem[0], 32'd10);
        check_val("t2_out1", out_mem[1], 32'd0);

        // bias scaling and rounding: (3<<5 + 16)>>5 = 3, (16+16)>>5 = 1
        clear_mem();
        set_cfg(1, 2, 5, 0);
        in_mem[0] = 32'd16;
        wmem[1][0] = 8'sd1;
        bias_mem[0] = 32'd3;
        run("t3", 27, e);
        check_val("t3_bias", out_mem[0], 32'd3);
        check_val("t3_round", out_mem[1], 32'd1);

        // saturation both ways
        clear_mem();
        set_cfg(1, 2, 0, 0);
        in_mem[0] = 32'd100;
        wmem[0][0] = 8'sd10;
        wmem[1][0] = -8'sd10;
        run("t4", 27, e);
        check_val("t4_sat_pos", out_mem[0], 32'd127);
        check_val("t4_sat_neg", out_mem[1], 32'hFFFF_FF80);

        // two tiles, out_ch = NUM_PE+3; unused lanes hold garbage weights/biases
        clear_mem();
        set_cfg(2, NUM_PE + 3, 0, 0);
        in_mem[0] = 32'd1;
        in_mem[1] = 32'd2;
        for (int o = 0; o < 32; o++) begin
            wmem[o][0] = (o < NUM_PE + 3) ? 8'(o) : 8'sd5;
            wmem[o][1] = (o < NUM_PE + 3) ? 8'sd1 : 8'sd7;
            bias_mem[o] = (o < NUM_PE + 3) ? 32'd0 : 32'd9;
        end
        run("t5", 66, e);
        check_val("t5_wr_cnt", 32'(wr_cnt), 32'(NUM_PE + 3));
        for (int o = 0; o < NUM_PE + 3; o++) begin
            check_val($sformatf("t5_out%0d", o), out_mem[o], 32'(o + 2));
        end
        check_val("t5_no_write_past", out_mem[NUM_PE + 3], 32'hDEAD_BEEF);
        check_val("t5_bad_wr", 32'(bad_wr), 32'd0);

        // illegal configs
        clear_mem();
        set_cfg(0, 2, 0, 0);
        run("t6", 5, e);
        check_val("t6_cfg_err", 32'(e), 32'd1);
        check_val("t6_no_writes", 32'(wr_cnt), 32'd0);
        set_cfg(4, 257, 0, 0);
        run("t6b", 5, e);
        check_val("t6b_cfg_err", 32'(e), 32'd1);
        check_val("t6b_no_writes", 32'(wr_cnt), 32'd0);

        // reset mid-MAC
        clear_mem();
        set_cfg(40, 2, 0, 0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (25) @(negedge clk);
        check_val("t7_in_mac", 32'(input_if.cs), 32'd1);
        rstn = 1'b0;
        #1;
        check_val("t7_rst_cs", 32'({param_if.cs, bias_if.cs, input_if.cs, output_if.cs, wgt_cs}), 32'd0);
        check_val("t7_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_val("t7_no_writes", 32'(wr_cnt), 32'd0);

        // fresh run after reset, legal config clears cfg_err state
        set_cfg(4, 2, 0, 0);
        for (int i = 0; i < 4; i++) begin
            in_mem[i] = 32'(i + 1);
            wmem[0][i] = 8'sd1;
            wmem[1][i] = -8'sd1;
        end
        run("t8", 30, e);
        check_val("t8_err", 32'(e), 32'd0);
        check_val("t8_out0", out_mem[0], 32'd10);
        check_val("t8_out1", out_mem[1], 32'hFFFF_FFF6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
